spi_flash_slave: RTL and testbench

- Synthesizable SPI NOR-flash responder that sits directly downstream of the APB SPI master.
- Consumes the master's spi_sck, spi_ss and spi_mosi, and drives spi_miso back, so XIP reads (command 0x03 plus a 24-bit address) can be verified without a DPI flash model.
- Runs entirely in the system clock domain: it oversamples the SPI pins and serves bytes from an internal byte-addressed word memory with a backdoor load port.

---
 rtl/spi_flash_slave_if.sv | 25 ++
 rtl/spi_flash_slave.sv | 137 +++++++++++++
 tb/tb_spi_flash_slave.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_slave_if.sv
// spi_flash_slave_if: SPI pins plus backdoor load port and status flags of the flash responder
interface spi_flash_slave_if #(
    parameter int AW     = 10,
    parameter int SS_NUM = 8
) ();
    logic              spi_sck;
    logic [SS_NUM-1:0] spi_ss;
    logic              spi_mosi;
    logic              spi_miso;
    logic              ld_en;
    logic [AW-1:0]     ld_addr;
    logic [31:0]       ld_data;
    logic              busy;
    logic              cmd_err;

    modport master (
        output spi_sck, spi_ss, spi_mosi, ld_en, ld_addr, ld_data,
        input  spi_miso, busy, cmd_err
    );

    modport slave (
        input  spi_sck, spi_ss, spi_mosi, ld_en, ld_addr, ld_data,
        output spi_miso, busy, cmd_err
    );
endinterface

// File: rtl/spi_flash_slave.sv
// spi_flash_slave: oversampled SPI mode-0 NOR-flash read responder (cmd 0x03) with backdoor-loaded word memory
module spi_flash_slave #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10,
    parameter int SS_IDX      = 0,
    parameter int SS_NUM      = 8
) (
    input logic              clock,
    input logic              reset,
    spi_flash_slave_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

    state_t        state, state_d;
    logic [1:0]    sck_sync, ss_sync, mosi_sync;
    logic          sck_prev, sck_rise, sel, mosi_s;
    logic [4:0]    bit_cnt, bit_cnt_d;
    logic [7:0]    cmd, cmd_d, cmd_shift;
    logic [AW+1:0] addr, addr_d, addr_shift, ptr, ptr_d, fetch_ptr;
    logic [7:0]    shreg, shreg_d, fetch_byte;
    logic          miso, miso_d, cmd_err, cmd_err_d;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   fetch_word;

    always_ff @(posedge clock) begin
        if (reset) begin
            sck_sync  <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], bus.spi_sck};
            ss_sync   <= {ss_sync[0], bus.spi_ss[SS_IDX]};
            mosi_sync <= {mosi_sync[0], bus.spi_mosi};
            sck_prev  <= sck_sync[1];
        end
    end

    assign sck_rise = sck_sync[1] & ~sck_prev;
    assign sel      = ~ss_sync[1];
    assign mosi_s   = mosi_sync[1];

    always_ff @(posedge clock) begin
        if (bus.ld_en) mem[bus.ld_addr] <= bus.ld_data;
    end

    // Only the low AW+2 address bits survive the shift, which gives the modulo-memory aliasing for free.
    assign cmd_shift  = {cmd[6:0], mosi_s};
    assign addr_shift = {addr[AW:0], mosi_s};
    assign fetch_ptr  = (state == ADDR) ? addr_shift : ptr + 1'b1;
    assign fetch_word = mem[fetch_ptr[AW+1:2]];
    assign fetch_byte = fetch_word[{fetch_ptr[1:0], 3'b000} +: 8];

    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        cmd_d     = cmd;
        addr_d    = addr;
        ptr_d     = ptr;
        shreg_d   = shreg;
        miso_d    = miso;
        cmd_err_d = 1'b0;
        if (state != IDLE && !sel) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    miso_d    = 1'b0;
                    bit_cnt_d = '0;
                    cmd_d     = '0;
                    addr_d    = '0;
                    if (sel) state_d = CMD;
                end
                CMD: if (sck_rise) begin
                    cmd_d     = cmd_shift;
                    bit_cnt_d = (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
                    if (bit_cnt == 5'd7) begin
                        state_d   = (cmd_shift == 8'h03) ? ADDR : IGNORE;
                        cmd_err_d = (cmd_shift != 8'h03);
                    end
                end
                ADDR: if (sck_rise) begin
                    addr_d    = addr_shift;
                    bit_cnt_d = (bit_cnt == 5'd23) ? 5'd0 : bit_cnt + 5'd1;
                    if (bit_cnt == 5'd23) begin
                        ptr_d   = fetch_ptr;
                        shreg_d = fetch_byte;
                        miso_d  = fetch_byte[7];
                        state_d = DATA;
                    end
                end
                DATA: if (sck_rise) begin
                    if (bit_cnt == 5'd7) begin
                        bit_cnt_d = '0;
                        ptr_d     = fetch_ptr;
                        shreg_d   = fetch_byte;
                        miso_d    = fetch_byte[7];
                    end else begin
                        bit_cnt_d = bit_cnt + 5'd1;
                        shreg_d   = {shreg[6:0], 1'b0};
                        miso_d    = shreg[6];
                    end
                end
                IGNORE: miso_d = 1'b0;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            cmd     <= '0;
            addr    <= '0;
            ptr     <= '0;
            shreg   <= '0;
            miso    <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            state   <= state_d;
            bit_cnt <= bit_cnt_d;
            cmd     <= cmd_d;
            addr    <= addr_d;
            ptr     <= ptr_d;
            shreg   <= shreg_d;
            miso    <= miso_d;
            cmd_err <= cmd_err_d;
        end
    end

    assign bus.spi_miso = miso;
    assign bus.busy     = (state != IDLE);
    assign bus.cmd_err  = cmd_err;
endmodule

// File: tb/tb_spi_flash_slave.sv
// tb_spi_flash_slave: table-driven and randomized read frames checked against a byte-array flash model
module tb_spi_flash_slave;
    localparam int DW = 1024;
    localparam int AW = 10;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    spi_flash_slave_if #(.AW(AW), .SS_NUM(8)) bus ();
    spi_flash_slave #(.DEPTH_WORDS(DW), .AW(AW), .SS_IDX(0), .SS_NUM(8)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [23:0] addr;
        logic [31:0] exp;
    } vec_t;

    logic [31:0] model [DW];
    logic [7:0]  rx [8];
    int          checks = 0;
    int          errors = 0;
    int          err_pulses = 0;
    logic        busy_drop, miso_seen;
    vec_t        vt [6];

    always @(negedge clock) if (bus.cmd_err) err_pulses++;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_byte(input int a);
        logic [31:0] w;
        w = model[(a >> 2) % DW];
        return w[8*(a%4) +: 8];
    endfunction

    task automatic ticks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic load(input int a, input logic [31:0] d);
        bus.ld_en   = 1'b1;
        bus.ld_addr = a[AW-1:0];
        bus.ld_data = d;
        model[a]    = d;
        ticks(1);
        bus.ld_en   = 1'b0;
    endtask

    task automatic sbit(input logic m, output logic s);
        bus.spi_mosi = m;
        ticks(2);
        s = bus.spi_miso;
        if (!bus.busy) busy_drop = 1'b1;
        bus.spi_sck = 1'b1;
        ticks(2);
        bus.spi_sck = 1'b0;
    endtask

    task automatic header(input logic [7:0] c, input logic [23:0] a, input int abits);
        logic b;
        bus.spi_ss = 8'hFE;
        ticks(3);
        busy_drop = 1'b0;
        miso_seen = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            sbit(c[i], b);
            miso_seen |= b;
        end
        for (int i = 23; i >= 24 - abits; i--) begin
            sbit(a[i], b);
            miso_seen |= b;
        end
    endtask

    task automatic data(input int n);
        logic b;
        for (int k = 0; k < n; k++)
            for (int i = 0; i < 8; i++) begin
                sbit(1'b0, b);
                rx[k] = {rx[k][6:0], b};
            end
    endtask

    task automatic deselect(input string name);
        int cnt = 0;
        bus.spi_ss = 8'hFF;
        while (bus.busy && cnt < 6) begin
            ticks(1);
            cnt++;
        end
        checks++;
        if (cnt < 2 || cnt > 4) begin
            errors++;
            $display("FAIL %s_busy_fall: busy fell after %0d clocks, required 2..4", name, cnt);
        end
        chk({name, "_miso_idle"}, {31'd0, bus.spi_miso}, 32'd0);
        ticks(2);
    endtask

    initial begin
        int   a, n, e0;
        logic b;
        vt[0] = '{24'h000000, 32'h78563412};
        vt[1] = '{24'h000003, 32'h12A5A5A5};
        vt[2] = '{24'h000FFE, 32'hADDE7856};
        vt[3] = '{24'h400000, 32'h78563412};
        vt[4] = '{24'h000004, 32'hA5A5A5A5};
        vt[5] = '{24'h000001, 32'h563412A5};
        bus.spi_sck  = 1'b0;
        bus.spi_ss   = 8'hFF;
        bus.spi_mosi = 1'b0;
        bus.ld_en    = 1'b0;
        bus.ld_addr  = '0;
        bus.ld_data  = '0;
        ticks(3);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_miso", {31'd0, bus.spi_miso}, 32'd0);
        chk("rst_cmd_err", {31'd0, bus.cmd_err}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < DW; i++) load(i, $urandom);
        load(0, 32'h12345678);
        load(1, 32'hA5A5A5A5);
        load(1023, 32'hDEADBEEF);

        for (int v = 0; v < 6; v++) begin
            header(8'h03, vt[v].addr, 24);
            data(4);
            chk($sformatf("vec%0d_bytes", v), {rx[0], rx[1], rx[2], rx[3]}, vt[v].exp);
            chk($sformatf("vec%0d_busy_held", v), {31'd0, busy_drop}, 32'd0);
            chk($sformatf("vec%0d_hdr_miso", v), {31'd0, miso_seen}, 32'd0);
            deselect($sformatf("vec%0d", v));
        end

        e0 = err_pulses;
        header(8'h0B, 24'h000000, 24);
        data(2);
        chk("ign_miso", {16'd0, rx[0], rx[1]} | {31'd0, miso_seen}, 32'd0);
        chk("ign_cmd_err_pulse", err_pulses - e0, 32'd1);
        deselect("ign");
        header(8'h03, 24'h000000, 24);
        data(4);
        chk("after_ign_bytes", {rx[0], rx[1], rx[2], rx[3]}, 32'h78563412);
        deselect("after_ign");

        e0 = err_pulses;
        header(8'h03, 24'h000000, 12);
        deselect("abort");
        header(8'h03, 24'h000004, 24);
        data(4);
        chk("after_abort_bytes", {rx[0], rx[1], rx[2], rx[3]}, 32'hA5A5A5A5);
        chk("abort_no_cmd_err", err_pulses - e0, 32'd0);
        deselect("after_abort");

        header(8'h03, 24'h000000, 24);
        data(1);
        for (int i = 0; i < 4; i++) sbit(1'b0, b);
        reset = 1'b1;
        ticks(1);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_miso", {31'd0, bus.spi_miso}, 32'd0);
        reset = 1'b0;
        ticks(4);
        header(8'h03, 24'h000000, 24);
        data(4);
        chk("midrst_rejoin_bytes", {rx[0], rx[1], rx[2], rx[3]}, 32'h12345678 >> 0 == 32'h12345678 ? 32'h78563412 : 32'h0);
        deselect("midrst");

        for (int r = 0; r < 8; r++) begin
            a = int'($urandom_range(0, 24'hFFFFFF));
            n = int'($urandom_range(1, 8));
            header(8'h03, a[23:0], 24);
            data(n);
            for (int k = 0; k < n; k++)
                chk($sformatf("rnd%0d_a%06h_b%0d", r, a, k), {24'd0, rx[k]}, {24'd0, model_byte(a + k)});
            deselect($sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
